// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetcher with a DEPTH-entry FIFO and a single
// outstanding memory request (IDLE / BUSY / DROP).
// Optional feature: define FETCH_ALIGN_CHK_EN to enable the misaligned
// redirect fault. Without it, fault is tied low and redirect_pc[1:0] is
// forced to 2'b00.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t           state, state_nxt;
  logic [31:0]      fetch_pc, fetch_pc_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [PTR_W-1:0] head, tail;
  logic [31:0]      fifo_instr [DEPTH];
  logic [31:0]      fifo_pc    [DEPTH];
  logic             push, pop, flush;
  logic [31:0]      target_pc;
  logic             misaligned;

  assign mem_req     = (state != IDLE);
  assign mem_addr    = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_instr[head] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[head]    : '0;

`ifdef FETCH_ALIGN_CHK_EN
  assign target_pc  = redirect_pc;
  assign misaligned = |redirect_pc[1:0];

  // Sticky fault: set by a misaligned redirect, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault <= 1'b0;
    else if (ce) fault <= fault | (redirect & misaligned);
  end
`else
  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  // Next-state, fetch address and FIFO push/pop/flush decisions.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    if (ce) begin
      if (redirect) begin
        // Redirect wins over push and pop; any returning data is discarded.
        flush = 1'b1;
        if (misaligned || fault) begin
          state_nxt = IDLE;
        end else begin
          fetch_pc_nxt = target_pc;
          case (state)
            IDLE:    state_nxt = BUSY;
            BUSY:    state_nxt = mem_ack ? BUSY : DROP;
            default: state_nxt = DROP;
          endcase
        end
      end else begin
        pop = instr_valid & instr_ready;
        case (state)
          IDLE: begin
            if (!fault && int'(count) < DEPTH) state_nxt = BUSY;
          end
          BUSY: begin
            if (mem_ack) begin
              push         = 1'b1;
              fetch_pc_nxt = fetch_pc + 32'd4;
              state_nxt    = (int'(count) + 1 - int'(pop) < DEPTH) ? BUSY : IDLE;
            end
          end
          default: begin
            // Stale word from before the redirect: drop it and refetch.
            if (mem_ack) state_nxt = BUSY;
          end
        endcase
      end
    end
  end

  // Occupancy follows push/pop; a flush empties the buffer.
  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = '0;
    else       count_nxt = CW'(int'(count) + int'(push) - int'(pop));
  end

  // Control state: FSM, fetch address, occupancy and FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (ce) begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      count    <= count_nxt;
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= PTR_W'(int'(tail) + 1);
        if (pop)  head <= PTR_W'(int'(head) + 1);
      end
    end
  end

  // FIFO storage; contents are only observed when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[tail] <= mem_rdata;
      fifo_pc[tail]    <= fetch_pc;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0000_0000, first fetch address after reset; DEPTH, 2, prefetch buffer entries (legal values 2 or 4).
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous reset, active-low (0 = reset).
REQ-004 Port ce  input  1  clock enable; when 0, all state holds.
REQ-005 Port mem_req  output  1  instruction read request to memory.
REQ-006 Port mem_addr  output  32  word address of the current request; equals fetch_pc.
REQ-007 Port mem_ack  input  1  memory accepts the request and presents data in the same cycle.
REQ-008 Port mem_rdata  input  32  instruction word; valid when mem_req and mem_ack are both 1.
REQ-009 Port instr_valid  output  1  the head buffer entry is available to the core.
REQ-010 Port instr  output  32  instruction word at the buffer head.
REQ-011 Port instr_pc  output  32  address of instr.
REQ-012 Port instr_ready  input  1  the core consumes the head entry (feeds the IR load).
REQ-013 Port redirect  input  1  the core requests a flush and a fetch restart.
REQ-014 Port redirect_pc  input  32  restart address, sampled when redirect is 1.
REQ-015 Port fault  output  1  misaligned redirect fault (see Configuration).

Function
REQ-016 The FSM SHALL have three states: IDLE (mem_req=0), BUSY (mem_req=1), and DROP (mem_req=1, the returning data is discarded).
- IDLE -> BUSY when count + 0 < DEPTH.
- BUSY, on ack: push {fetch_pc, mem_rdata} and set fetch_pc += 4; if the buffer still has space after the push and any same-cycle pop, stay in BUSY, else go to IDLE.
- DROP, on ack: go to BUSY and discard mem_rdata.
REQ-017 At most one request SHALL be outstanding, and mem_addr SHALL be stable while mem_req=1 until ack.
REQ-018 fetch_pc SHALL wrap modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-019 instr_valid SHALL be 1 iff count != 0; a pop SHALL occur when instr_valid and instr_ready and ce are all 1.
REQ-020 Push and pop SHALL be allowed in the same cycle; count is then unchanged and order is preserved.
REQ-021 The buffer SHALL never overflow, and a push SHALL be impossible when count = DEPTH.
REQ-022 Latency: an ack in cycle N SHALL make instr_valid=1 in cycle N+1 when the buffer was empty.
REQ-023 Redirect SHALL take priority over push and pop. On redirect:
- the buffer is flushed (count=0) and fetch_pc <= redirect_pc;
- from BUSY with no ack this cycle, go to DROP; from BUSY with ack this cycle, discard the data and go to BUSY.
REQ-024 A redirect while in DROP SHALL update fetch_pc only and stay in DROP.
REQ-025 When ce=0, the FSM, buffer, fetch_pc and fault SHALL hold, and mem_ack and redirect SHALL be ignored.

Reset
REQ-026 reset=0 SHALL immediately force:
- state IDLE, fetch_pc = RESET_PC, count = 0;
- mem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0, fault = 0.
REQ-027 Reset asserted mid-request SHALL abandon the request, and the first request after release SHALL be to RESET_PC.

Configuration
REQ-028 Macro FETCH_ALIGN_CHK_EN, when defined:
- a redirect with redirect_pc[1:0] != 0 sets fault=1 (sticky until reset), flushes the buffer and forces IDLE with no further requests.
- When undefined, fault is tied to 0 and redirect_pc[1:0] is treated as 2'b00.

Verification
REQ-029 Release reset with RESET_PC=0, ce=1, mem_ack=1 and instr_ready=0 -> addresses 0 and 4 are fetched, mem_req=0 afterwards, and instr_pc=0.
REQ-030 mem_ack delayed 3 cycles -> mem_addr is held stable, and instr_valid rises exactly 1 cycle after the ack.
REQ-031 instr_ready=1 continuously with ack every cycle -> instr_pc = 0, 4, 8, ... with no gaps or duplicates, and count is stable through simultaneous push/pop.
REQ-032 redirect to 0x100 while BUSY with ack delayed 2 cycles -> the stale word is dropped, and the next instr_pc is 0x100.
REQ-033 redirect_pc=0x102 with FETCH_ALIGN_CHK_EN defined -> fault=1 and mem_req=0 until reset; without the macro -> fetch from 0x100.
REQ-034 fetch_pc=0xFFFF_FFFC -> the next mem_addr is 0x0000_0000; reset asserted mid-BUSY -> mem_req=0 immediately.
